// File: rtl/regs_shadow_bank_pkg.sv
// Shared definitions for the double-buffered generator register bank.
// Holds the per-channel word offset map, the CTRL/STATUS bit positions,
// the default parameter word type and the per-channel FSM state encoding.
package regs_shadow_bank_pkg;

  localparam int PARAM_SIZE = 32;
  typedef logic [PARAM_SIZE-1:0] param_t;

  // Per-channel word offsets (addr[6:0]); table offsets are bases, +i for line i
  localparam logic [6:0] OFS_LINEA     = 7'h00;
  localparam logic [6:0] OFS_LINET     = 7'h10;
  localparam logic [6:0] OFS_LINET_INT = 7'h20;
  localparam logic [6:0] OFS_OFFSET    = 7'h30;
  localparam logic [6:0] OFS_LINENMB   = 7'h40;
  localparam logic [6:0] OFS_REPEAT    = 7'h41;
  localparam logic [6:0] OFS_CTRL      = 7'h42;
  localparam logic [6:0] OFS_STATUS    = 7'h43;

  localparam int CTRL_COMMIT    = 0;
  localparam int CTRL_CLR_ERR   = 1;
  localparam int STATUS_PENDING = 0;
  localparam int STATUS_ERR     = 1;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } ch_state_e;

endpackage

// File: rtl/regs_shadow_bank_if.sv
// Host register bus for regs_shadow_bank.
// Handshake: wr_en and rd_en are single-cycle strobes with no ready/backpressure;
// the bank always accepts. A write lands on the edge that samples wr_en. For every
// cycle rd_en is high, rd_valid is high exactly one cycle later with rd_data.
// Ports: wr_en, rd_en, addr, wr_data (host -> bank); rd_data, rd_valid (bank -> host).
interface regs_shadow_bank_if #(
  parameter int ADDR_W     = 10,
  parameter int PARAM_SIZE = 32
);
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_W-1:0]     addr;
  logic [PARAM_SIZE-1:0] wr_data;
  logic [PARAM_SIZE-1:0] rd_data;
  logic                  rd_valid;

  modport master (output wr_en, rd_en, addr, wr_data, input rd_data, rd_valid);
  modport slave  (input wr_en, rd_en, addr, wr_data, output rd_data, rd_valid);
endinterface

// File: rtl/regs_shadow_bank_channel.sv
// One generator channel: shadow register set, active register set, commit FSM
// and line-count validation.
// Ports: clk/rst; wr_en (already qualified for this channel), ofs, wr_data;
// gen_run/gen_sync from the generator; rd_word = combinational shadow/STATUS
// view of ofs; commit_ack/commit_err; state (FSM debug); act_* registered tables.
module regs_shadow_bank_channel
  import regs_shadow_bank_pkg::*;
#(
  parameter int PARAM_SIZE = 32,
  parameter int POINTS     = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [6:0]                   ofs,
  input  logic [PARAM_SIZE-1:0]        wr_data,
  input  logic                         gen_run,
  input  logic                         gen_sync,
  output logic [PARAM_SIZE-1:0]        rd_word,
  output logic                         commit_ack,
  output logic                         commit_err,
  output ch_state_e                    state,
  output logic [POINTS*PARAM_SIZE-1:0] act_linea,
  output logic [POINTS*PARAM_SIZE-1:0] act_linet,
  output logic [POINTS*PARAM_SIZE-1:0] act_linet_int,
  output logic [POINTS*PARAM_SIZE-1:0] act_offset,
  output logic [PARAM_SIZE-1:0]        act_linenmb,
  output logic [PARAM_SIZE-1:0]        act_repeat
);

  logic [PARAM_SIZE-1:0] sh_linea [POINTS];
  logic [PARAM_SIZE-1:0] sh_linet [POINTS];
  logic [PARAM_SIZE-1:0] sh_linet_int [POINTS];
  logic [PARAM_SIZE-1:0] sh_offset [POINTS];
  logic [PARAM_SIZE-1:0] sh_linenmb, sh_repeat;

  logic [PARAM_SIZE-1:0] ac_linea [POINTS];
  logic [PARAM_SIZE-1:0] ac_linet [POINTS];
  logic [PARAM_SIZE-1:0] ac_linet_int [POINTS];
  logic [PARAM_SIZE-1:0] ac_offset [POINTS];

  ch_state_e  next_state;
  logic [3:0] idx;
  logic [2:0] tbl;
  logic       idx_ok, ctrl_wr, do_apply, lnmb_ok, apply_ok;

  assign idx      = ofs[3:0];
  assign tbl      = ofs[6:4];
  assign idx_ok   = ({1'b0, idx} < 5'(POINTS));
  assign ctrl_wr  = wr_en && (ofs == OFS_CTRL);
  assign lnmb_ok  = (sh_linenmb != '0) && (sh_linenmb <= PARAM_SIZE'(POINTS));
  assign apply_ok = do_apply && lnmb_ok;

  // Requests arriving while PENDING are dropped on purpose: one request, one ack.
  always_comb begin
    next_state = state;
    do_apply   = 1'b0;
    case (state)
      ST_IDLE:    if (ctrl_wr && wr_data[CTRL_COMMIT]) next_state = ST_PENDING;
      ST_PENDING: if (gen_sync || !gen_run) begin
                    do_apply   = 1'b1;
                    next_state = ST_IDLE;
                  end
      default:    next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Shadow writes; the copy below reads the pre-edge shadow, so a write in the
  // apply cycle stays in shadow only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < POINTS; p++) begin
        sh_linea[p] <= '0; sh_linet[p] <= '0; sh_linet_int[p] <= '0; sh_offset[p] <= '0;
      end
      sh_linenmb <= '0;
      sh_repeat  <= '0;
    end else if (wr_en) begin
      case (tbl)
        3'd0: if (idx_ok) sh_linea[idx]     <= wr_data;
        3'd1: if (idx_ok) sh_linet[idx]     <= wr_data;
        3'd2: if (idx_ok) sh_linet_int[idx] <= wr_data;
        3'd3: if (idx_ok) sh_offset[idx]    <= wr_data;
        3'd4: begin
          if (ofs == OFS_LINENMB) sh_linenmb <= wr_data;
          if (ofs == OFS_REPEAT)  sh_repeat  <= wr_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < POINTS; p++) begin
        ac_linea[p] <= '0; ac_linet[p] <= '0; ac_linet_int[p] <= '0; ac_offset[p] <= '0;
      end
      act_linenmb <= '0;
      act_repeat  <= '0;
      commit_ack  <= 1'b0;
      commit_err  <= 1'b0;
    end else begin
      commit_ack <= apply_ok;
      if (apply_ok) begin
        for (int p = 0; p < POINTS; p++) begin
          ac_linea[p]     <= sh_linea[p];
          ac_linet[p]     <= sh_linet[p];
          ac_linet_int[p] <= sh_linet_int[p];
          ac_offset[p]    <= sh_offset[p];
        end
        act_linenmb <= sh_linenmb;
        act_repeat  <= sh_repeat;
      end
      // Clear-err in the same write as a commit request happens before the
      // request can be evaluated, since apply is at least one cycle later.
      if (do_apply)                             commit_err <= !lnmb_ok;
      else if (ctrl_wr && wr_data[CTRL_CLR_ERR]) commit_err <= 1'b0;
    end
  end

  for (genvar p = 0; p < POINTS; p++) begin : g_pack
    assign act_linea[p*PARAM_SIZE +: PARAM_SIZE]     = ac_linea[p];
    assign act_linet[p*PARAM_SIZE +: PARAM_SIZE]     = ac_linet[p];
    assign act_linet_int[p*PARAM_SIZE +: PARAM_SIZE] = ac_linet_int[p];
    assign act_offset[p*PARAM_SIZE +: PARAM_SIZE]    = ac_offset[p];
  end

  always_comb begin
    rd_word = '0;
    case (tbl)
      3'd0: if (idx_ok) rd_word = sh_linea[idx];
      3'd1: if (idx_ok) rd_word = sh_linet[idx];
      3'd2: if (idx_ok) rd_word = sh_linet_int[idx];
      3'd3: if (idx_ok) rd_word = sh_offset[idx];
      3'd4: begin
        if (ofs == OFS_LINENMB) rd_word = sh_linenmb;
        if (ofs == OFS_REPEAT)  rd_word = sh_repeat;
        if (ofs == OFS_STATUS) begin
          rd_word[STATUS_PENDING] = (state == ST_PENDING);
          rd_word[STATUS_ERR]     = commit_err;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/regs_shadow_bank.sv
// Multi-channel double-buffered register bank for the piecewise-linear generators.
// Ports: clk, rst (sync, active-high); bus (host register interface, slave side);
// gen_run/gen_sync per channel; commit_ack/commit_err per channel; ch_state
// (per-channel FSM state); act_* active tables packed [ch][pt].
module regs_shadow_bank
  import regs_shadow_bank_pkg::*;
#(
  parameter int PARAM_SIZE = 32,
  parameter int POINTS     = 9,
  parameter int CHANNELS   = 2,
  parameter int ADDR_W     = 10
) (
  input  logic                                  clk,
  input  logic                                  rst,
  regs_shadow_bank_if.slave                     bus,
  input  logic [CHANNELS-1:0]                   gen_run,
  input  logic [CHANNELS-1:0]                   gen_sync,
  output logic [CHANNELS-1:0]                   commit_ack,
  output logic [CHANNELS-1:0]                   commit_err,
  output ch_state_e                             ch_state [CHANNELS],
  output logic [CHANNELS*POINTS*PARAM_SIZE-1:0] act_linea,
  output logic [CHANNELS*POINTS*PARAM_SIZE-1:0] act_linet,
  output logic [CHANNELS*POINTS*PARAM_SIZE-1:0] act_linet_int,
  output logic [CHANNELS*POINTS*PARAM_SIZE-1:0] act_offset,
  output logic [CHANNELS*PARAM_SIZE-1:0]        act_linenmb,
  output logic [CHANNELS*PARAM_SIZE-1:0]        act_repeat
);

  localparam int CH_W = ADDR_W - 7;
  localparam int TW   = POINTS * PARAM_SIZE;

  logic [CH_W-1:0]       ch_sel;
  logic [6:0]            ofs;
  logic [PARAM_SIZE-1:0] rd_word [CHANNELS];
  logic [PARAM_SIZE-1:0] rd_mux;

  assign ch_sel = bus.addr[ADDR_W-1:7];
  assign ofs    = bus.addr[6:0];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    // Channel numbers >= CHANNELS match no instance, so such writes vanish.
    regs_shadow_bank_channel #(
      .PARAM_SIZE(PARAM_SIZE),
      .POINTS    (POINTS)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (bus.wr_en && (ch_sel == CH_W'(g))),
      .ofs          (ofs),
      .wr_data      (bus.wr_data),
      .gen_run      (gen_run[g]),
      .gen_sync     (gen_sync[g]),
      .rd_word      (rd_word[g]),
      .commit_ack   (commit_ack[g]),
      .commit_err   (commit_err[g]),
      .state        (ch_state[g]),
      .act_linea    (act_linea[g*TW +: TW]),
      .act_linet    (act_linet[g*TW +: TW]),
      .act_linet_int(act_linet_int[g*TW +: TW]),
      .act_offset   (act_offset[g*TW +: TW]),
      .act_linenmb  (act_linenmb[g*PARAM_SIZE +: PARAM_SIZE]),
      .act_repeat   (act_repeat[g*PARAM_SIZE +: PARAM_SIZE])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (ch_sel == CH_W'(c)) rd_mux = rd_word[c];
  end

  // Registered read: a same-cycle write is not yet in shadow, so the old value returns.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) bus.rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_regs_shadow_bank.sv
module tb_regs_shadow_bank;
  import regs_shadow_bank_pkg::*;

  localparam int PS = 32;
  localparam int PTS = 9;
  localparam int CHS = 2;
  localparam int AW = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regs_shadow_bank_if #(.ADDR_W(AW), .PARAM_SIZE(PS)) bus ();

  logic [CHS-1:0]         gen_run, gen_sync, commit_ack, commit_err;
  ch_state_e              ch_state [CHS];
  logic [CHS*PTS*PS-1:0]  act_linea, act_linet, act_linet_int, act_offset;
  logic [CHS*PS-1:0]      act_linenmb, act_repeat;

  regs_shadow_bank #(.PARAM_SIZE(PS), .POINTS(PTS), .CHANNELS(CHS), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .gen_run      (gen_run),
    .gen_sync     (gen_sync),
    .commit_ack   (commit_ack),
    .commit_err   (commit_err),
    .ch_state     (ch_state),
    .act_linea    (act_linea),
    .act_linet    (act_linet),
    .act_linet_int(act_linet_int),
    .act_offset   (act_offset),
    .act_linenmb  (act_linenmb),
    .act_repeat   (act_repeat)
  );

  // ---------------- scoreboard state ----------------
  logic [PS-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int ack_cnt [CHS];
  logic rd_en_d = 1'b0;

  task automatic check(input string name, input logic [PS-1:0] act, input logic [PS-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [PS-1:0] a_linea(input int ch, input int pt);
    return act_linea[(ch*PTS+pt)*PS +: PS];
  endfunction

  function automatic logic [PS-1:0] a_linenmb(input int ch);
    return act_linenmb[ch*PS +: PS];
  endfunction

  // ---------------- monitor ----------------
  always @(posedge clk) rd_en_d <= bus.rd_en;

  always @(negedge clk) begin
    if (!rst) begin
      for (int c = 0; c < CHS; c++)
        if (commit_ack[c]) ack_cnt[c] <= ack_cnt[c] + 1;
      if (bus.rd_valid || rd_en_d)
        check("rd_valid_timing", {31'b0, bus.rd_valid}, {31'b0, rd_en_d});
      if (bus.rd_valid) begin
        if (exp_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
        else check("rd_data", bus.rd_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input logic [6:0] ofs, input logic [PS-1:0] d);
    bus.addr    = AW'(ch * 128) | AW'(ofs);
    bus.wr_data = d;
    bus.wr_en   = 1'b1;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic rd(input int ch, input logic [6:0] ofs, input logic [PS-1:0] exp);
    bus.addr  = AW'(ch * 128) | AW'(ofs);
    bus.rd_en = 1'b1;
    exp_q.push_back(exp);
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic rdwr(input int ch, input logic [6:0] ofs, input logic [PS-1:0] d,
                      input logic [PS-1:0] exp);
    bus.addr    = AW'(ch * 128) | AW'(ofs);
    bus.wr_data = d;
    bus.wr_en   = 1'b1;
    bus.rd_en   = 1'b1;
    exp_q.push_back(exp);
    tick();
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a0, a1;
    for (int c = 0; c < CHS; c++) ack_cnt[c] = 0;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = '0; bus.wr_data = '0;
    gen_run = '0; gen_sync = '0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;

    // Reset state
    rd(0, OFS_LINEA, 32'h0);
    rd(0, OFS_STATUS, 32'h0);
    check("rst_act_linenmb0", a_linenmb(0), 32'h0);
    check("rst_act_linenmb1", a_linenmb(1), 32'h0);
    check("rst_commit_err", {30'b0, commit_err}, 32'h0);

    // Immediate commit on a stopped generator
    wr(1, OFS_LINEA + 7'd3, 32'h1234);
    wr(1, OFS_LINENMB, 32'd4);
    wr(1, OFS_CTRL, 32'd1);
    check("ack_before_apply", {30'b0, commit_ack}, 32'h0);
    tick();
    check("ack_ch1_immediate", {30'b0, commit_ack}, 32'h2);
    check("act_linea_1_3", a_linea(1, 3), 32'h1234);
    check("act_linenmb_1", a_linenmb(1), 32'd4);
    check("act_linenmb_0_untouched", a_linenmb(0), 32'h0);
    tick();
    check("ack_one_cycle", {30'b0, commit_ack}, 32'h0);

    // Commit waits for gen_sync while running
    gen_run = 2'b11;
    wr(0, OFS_LINENMB, 32'd5);
    wr(0, OFS_CTRL, 32'd1);
    tick(20);
    check("act_hold_while_pending", a_linenmb(0), 32'h0);
    check("no_ack_while_pending", 32'(ack_cnt[0]), 32'd0);
    rd(0, OFS_STATUS, 32'h1);
    gen_sync = 2'b01;
    tick();
    gen_sync = 2'b00;
    check("ack_on_sync", {30'b0, commit_ack}, 32'h1);
    check("act_linenmb_0_sync", a_linenmb(0), 32'd5);
    rd(0, OFS_STATUS, 32'h0);

    // Rejected commits: linenmb = 0 and POINTS+1
    gen_run = 2'b00;
    wr(0, OFS_LINENMB, 32'd0);
    wr(0, OFS_CTRL, 32'd1);
    tick();
    check("err_zero", {30'b0, commit_err}, 32'h1);
    check("err_zero_no_ack", {30'b0, commit_ack}, 32'h0);
    check("err_zero_act_kept", a_linenmb(0), 32'd5);
    rd(0, OFS_STATUS, 32'h2);
    wr(0, OFS_CTRL, 32'd2);
    check("err_cleared", {30'b0, commit_err}, 32'h0);
    wr(0, OFS_LINENMB, 32'(PTS + 1));
    wr(0, OFS_CTRL, 32'd1);
    tick();
    check("err_over", {30'b0, commit_err}, 32'h1);
    check("err_over_no_ack", {30'b0, commit_ack}, 32'h0);
    check("err_over_act_kept", a_linenmb(0), 32'd5);

    // Boundary linenmb = POINTS with clear+commit in one write
    wr(0, OFS_LINENMB, 32'(PTS));
    wr(0, OFS_CTRL, 32'd3);
    check("clr_then_pend_err", {30'b0, commit_err}, 32'h0);
    tick();
    check("ack_points", {30'b0, commit_ack}, 32'h1);
    check("act_linenmb_points", a_linenmb(0), 32'(PTS));

    // Shadow write in the apply cycle, duplicate request while pending
    tick(2);
    a0 = ack_cnt[0];
    gen_run = 2'b01;
    wr(0, OFS_CTRL, 32'd1);
    wr(0, OFS_CTRL, 32'd1);
    gen_sync = 2'b01;
    wr(0, OFS_LINEA, 32'hAA);
    gen_sync = 2'b00;
    check("ack_apply_cycle", {30'b0, commit_ack}, 32'h1);
    check("act_linea_old", a_linea(0, 0), 32'h0);
    rd(0, OFS_LINEA, 32'hAA);
    tick(5);
    check("single_ack", 32'(ack_cnt[0] - a0), 32'd1);
    gen_run = 2'b00;

    // Unmapped / out-of-range and read-during-write
    wr(0, 7'h50, 32'hDEAD);
    rd(0, 7'h50, 32'h0);
    wr(0, OFS_LINEA + 7'(PTS), 32'hBEEF);
    rd(0, OFS_LINEA + 7'(PTS), 32'h0);
    rd(2, OFS_LINEA, 32'h0);
    rd(0, OFS_CTRL, 32'h0);
    wr(0, OFS_REPEAT, 32'd7);
    rd(0, OFS_REPEAT, 32'd7);
    rdwr(0, OFS_REPEAT, 32'd8, 32'd7);
    rd(0, OFS_REPEAT, 32'd8);
    rd(1, OFS_LINEA + 7'd3, 32'h1234);

    // Reset while pending drops the request
    gen_run = 2'b10;
    wr(1, OFS_CTRL, 32'd1);
    rd(1, OFS_STATUS, 32'h1);
    tick(2);
    a1 = ack_cnt[1];
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    gen_run = 2'b00;
    tick(5);
    check("no_ack_after_rst", 32'(ack_cnt[1] - a1), 32'd0);
    check("act_linenmb_1_rst", a_linenmb(1), 32'h0);
    rd(1, OFS_STATUS, 32'h0);
    tick(3);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
